// File: rtl/vc_arbiter_rr.sv
// Virtual-channel arbiter: picks one non-empty VC FIFO (round-robin or
// fixed priority) and pops a burst of up to burst_len words from it,
// honouring downstream almost-full backpressure.
module vc_arbiter_rr #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_CH),
  parameter int unsigned BURST_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [NUM_CH-1:0]  empty_vchannel,
  input  logic               prio_mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               dest_almost_full,
  output logic [NUM_CH-1:0]  pop,
  output logic [NUM_CH-1:0]  valid_channel,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [BURST_W-1:0] burst_cnt;

  logic [NUM_CH-1:0]  req;
  logic               has_req;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic               pr_found;
  logic [IDX_W-1:0]   pr_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_CH-1:0]  win_oh;
  logic [NUM_CH-1:0]  grant_oh;
  logic               grant_empty;
  logic               pop_ok;
  logic [BURST_W-1:0] limit;
  logic               last_pop;

  assign req     = ~empty_vchannel;
  assign has_req = |req;

  // Round-robin search starting just after the previous winner, wrapping
  // modulo NUM_CH so out-of-range indices never appear.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      if (!rr_found && req[(32'(last_grant) + off) % NUM_CH]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((32'(last_grant) + off) % NUM_CH);
      end
    end
  end

  // Fixed-priority search: lowest requesting index wins.
  always_comb begin
    pr_found = 1'b0;
    pr_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!pr_found && req[i]) begin
        pr_found = 1'b1;
        pr_idx   = IDX_W'(i);
      end
    end
  end

  assign win_idx = prio_mode ? pr_idx : rr_idx;

  // One-hot decodes of the arbitration winner and the held grant.
  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      win_oh[i]   = (32'(win_idx) == i);
      grant_oh[i] = (32'(grant_idx) == i);
    end
  end

  assign grant_empty = |(grant_oh & empty_vchannel);

  // Zero-latency pop toward the granted VC; reset kills it immediately.
  assign pop_ok = (state == BURST) && enb && !dest_almost_full && !grant_empty && !rst;
  assign pop    = pop_ok ? grant_oh : '0;

  // burst_len of 0 behaves as 1, so both map to a limit of 0.
  assign limit    = (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
  assign last_pop = pop_ok && (burst_cnt == limit);

  // Arbitration / burst state machine with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_CH - 1);
      burst_cnt     <= '0;
      valid_channel <= '0;
      grant_idx     <= '0;
      busy          <= 1'b0;
    end else if (enb) begin
      case (state)
        IDLE: begin
          if (!dest_almost_full && has_req) begin
            grant_idx     <= win_idx;
            valid_channel <= win_oh;
            busy          <= 1'b1;
            burst_cnt     <= '0;
            state         <= BURST;
          end
        end
        BURST: begin
          // An empty granted VC ends the burst even under backpressure.
          if (grant_empty || last_pop) begin
            last_grant    <= grant_idx;
            valid_channel <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (pop_ok) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_arbiter_rr.sv
// Directed bench for vc_arbiter_rr: a 4-channel and a 5-channel instance
// share controls; expected grants and pops are hand-derived per cycle.
module tb_vc_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       prio_mode;
  logic [2:0] burst_len;
  logic       dest_almost_full;

  logic [3:0] empty4, pop4, valid4;
  logic [1:0] gidx4;
  logic       busy4;

  logic [4:0] empty5, pop5, valid5;
  logic [2:0] gidx5;
  logic       busy5;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  vc_arbiter_rr #(.NUM_CH(4), .BURST_W(3)) u4 (
    .clk(clk), .rst(rst), .enb(enb), .empty_vchannel(empty4),
    .prio_mode(prio_mode), .burst_len(burst_len),
    .dest_almost_full(dest_almost_full), .pop(pop4),
    .valid_channel(valid4), .grant_idx(gidx4), .busy(busy4)
  );

  vc_arbiter_rr #(.NUM_CH(5), .BURST_W(3)) u5 (
    .clk(clk), .rst(rst), .enb(enb), .empty_vchannel(empty5),
    .prio_mode(prio_mode), .burst_len(burst_len),
    .dest_almost_full(dest_almost_full), .pop(pop5),
    .valid_channel(valid5), .grant_idx(gidx5), .busy(busy5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] e4);
    rst    = 1'b1;
    empty4 = e4;
    enb    = 1'b1;
    dest_almost_full = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e4, e5;
    rst = 1'b1; enb = 1'b1; prio_mode = 1'b0; burst_len = 3'd2;
    dest_almost_full = 1'b0; empty4 = '0; empty5 = '0;

    // Reset values with all VCs requesting
    nxt();
    chk("rst_pop4", 32'(pop4), 0);
    chk("rst_valid4", 32'(valid4), 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_gidx4", 32'(gidx4), 0);
    chk("rst_pop5", 32'(pop5), 0);
    rst = 1'b0;

    // Round-robin rotation on both instances, burst_len=2: pop,pop,idle
    for (int g = 0; g < 6; g++) begin
      e4 = 32'(g % 4);
      e5 = 32'(g % 5);
      nxt();
      chk("rr_gidx4", 32'(gidx4), e4);
      chk("rr_valid4", 32'(valid4), 32'(1) << e4);
      chk("rr_busy4", 32'(busy4), 1);
      chk("rr_pop4a", 32'(pop4), 32'(1) << e4);
      chk("rr_gidx5", 32'(gidx5), e5);
      chk("rr_pop5a", 32'(pop5), 32'(1) << e5);
      nxt();
      chk("rr_pop4b", 32'(pop4), 32'(1) << e4);
      chk("rr_gidx4_hold", 32'(gidx4), e4);
      chk("rr_pop5b", 32'(pop5), 32'(1) << e5);
      nxt();
      chk("rr_idle_pop4", 32'(pop4), 0);
      chk("rr_idle_busy4", 32'(busy4), 0);
      chk("rr_idle_valid4", 32'(valid4), 0);
      chk("rr_idle_gidx4", 32'(gidx4), e4);
      chk("rr_idle_pop5", 32'(pop5), 0);
    end

    // Mid-burst asynchronous reset
    nxt();
    chk("mid_pop_before", 32'(pop4), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pop", 32'(pop4), 0);
    chk("mid_rst_valid", 32'(valid4), 0);
    chk("mid_rst_busy", 32'(busy4), 0);
    chk("mid_rst_gidx", 32'(gidx4), 0);
    nxt();
    rst = 1'b0;
    nxt();
    chk("post_rst_gidx", 32'(gidx4), 0);
    chk("post_rst_valid", 32'(valid4), 32'h1);

    // Fixed priority: VC0 and VC2 requesting, burst_len=1
    prio_mode = 1'b1;
    burst_len = 3'd1;
    do_reset(4'b1010);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("prio_gidx", 32'(gidx4), 0);
      chk("prio_pop", 32'(pop4), 32'h1);
      nxt();
      chk("prio_idle_pop", 32'(pop4), 0);
      chk("prio_idle_busy", 32'(busy4), 0);
    end
    empty4 = 4'b1011;
    nxt();
    chk("prio_vc2_gidx", 32'(gidx4), 2);
    chk("prio_vc2_valid", 32'(valid4), 32'h4);
    chk("prio_vc2_pop", 32'(pop4), 32'h4);

    // Backpressure during a VC1 burst of 4
    prio_mode = 1'b0;
    burst_len = 3'd4;
    do_reset(4'b1101);
    nxt();
    chk("bp_gidx", 32'(gidx4), 1);
    chk("bp_pop1", 32'(pop4), 32'h2);
    nxt();
    chk("bp_pop2", 32'(pop4), 32'h2);
    for (int k = 0; k < 3; k++) begin
      nxt();
      dest_almost_full = 1'b1;
      #1;
      chk("bp_stall_pop", 32'(pop4), 0);
      chk("bp_stall_valid", 32'(valid4), 32'h2);
      chk("bp_stall_busy", 32'(busy4), 1);
    end
    nxt();
    dest_almost_full = 1'b0;
    #1;
    chk("bp_pop3", 32'(pop4), 32'h2);
    nxt();
    chk("bp_pop4", 32'(pop4), 32'h2);
    nxt();
    chk("bp_end_pop", 32'(pop4), 0);
    chk("bp_end_busy", 32'(busy4), 0);

    // Early empty on VC3 after one pop (last_grant was 1)
    empty4 = 4'b0111;
    nxt();
    chk("ee_gidx", 32'(gidx4), 3);
    chk("ee_pop1", 32'(pop4), 32'h8);
    nxt();
    empty4 = 4'b1111;
    #1;
    chk("ee_empty_pop", 32'(pop4), 0);
    chk("ee_empty_busy", 32'(busy4), 1);
    nxt();
    chk("ee_exit_busy", 32'(busy4), 0);
    chk("ee_exit_valid", 32'(valid4), 0);
    chk("ee_exit_gidx", 32'(gidx4), 3);
    empty4 = 4'b0000;
    nxt();
    chk("ee_next_gidx", 32'(gidx4), 0);

    // Enable low for 5 cycles mid-burst
    burst_len = 3'd4;
    do_reset(4'b0000);
    nxt();
    chk("en_pop1", 32'(pop4), 32'h1);
    for (int k = 0; k < 5; k++) begin
      nxt();
      enb = 1'b0;
      #1;
      chk("en_off_pop", 32'(pop4), 0);
      chk("en_off_busy", 32'(busy4), 1);
      chk("en_off_valid", 32'(valid4), 32'h1);
    end
    nxt();
    enb = 1'b1;
    #1;
    chk("en_pop2", 32'(pop4), 32'h1);
    nxt();
    chk("en_pop3", 32'(pop4), 32'h1);
    nxt();
    chk("en_pop4", 32'(pop4), 32'h1);
    nxt();
    chk("en_end_pop", 32'(pop4), 0);
    chk("en_end_busy", 32'(busy4), 0);
    nxt();
    chk("en_next_gidx", 32'(gidx4), 1);

    // burst_len=0 behaves as one pop per grant
    burst_len = 3'd0;
    do_reset(4'b0000);
    for (int g = 0; g < 3; g++) begin
      nxt();
      chk("z_gidx", 32'(gidx4), 32'(g));
      chk("z_pop", 32'(pop4), 32'(1) << g);
      nxt();
      chk("z_idle_pop", 32'(pop4), 0);
      chk("z_idle_busy", 32'(busy4), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
